// File: rtl/sprite_dma.sv
// OAM sprite DMA: a CPU write of page N to the trigger address stalls the CPU and copies
// N00-NFF into OAMDATA as alternating read/write bus cycles; outputs come from registered state.
module sprite_dma #(
  parameter logic [15:0] DMA_TRIGGER_ADDRESS = 16'h4014,
  parameter logic [15:0] OAMDATA_ADDRESS     = 16'h2004,
  parameter int          TRANSFER_LENGTH     = 256
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic [15:0] i_cpu_address,
  input  logic [7:0]  i_cpu_data,
  input  logic        i_cpu_rw,
  input  logic [7:0]  i_data,
  output logic        o_cpu_rdy,
  output logic        o_dma_active,
  output logic [15:0] o_address,
  output logic        o_rw,
  output logic [7:0]  o_data,
  output logic        o_busy,
  output logic        o_done
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_HALT,
    S_ALIGN,
    S_READ,
    S_WRITE
  } state_t;

  localparam logic [8:0] LAST_INDEX = 9'(TRANSFER_LENGTH - 1);

  state_t      r_state;
  logic [7:0]  r_page;
  logic [8:0]  r_index;
  logic [7:0]  r_latch;
  logic        r_parity;
  logic        w_trigger;

  // The o_done cycle is the IDLE re-entry cycle; a trigger landing there is dropped.
  assign w_trigger = !i_cpu_rw && (i_cpu_address == DMA_TRIGGER_ADDRESS) && !o_done;

  assign o_data = (r_state == S_WRITE) ? r_latch : 8'h00;

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_state      <= S_IDLE;
      r_page       <= 8'h00;
      r_index      <= 9'd0;
      r_latch      <= 8'h00;
      r_parity     <= 1'b0;
      o_cpu_rdy    <= 1'b1;
      o_dma_active <= 1'b0;
      o_address    <= 16'h0000;
      o_rw         <= 1'b1;
      o_busy       <= 1'b0;
      o_done       <= 1'b0;
    end else begin
      r_parity <= ~r_parity;
      o_done   <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_trigger) begin
            r_page    <= i_cpu_data;
            r_index   <= 9'd0;
            r_state   <= S_HALT;
            o_cpu_rdy <= 1'b0;
            o_busy    <= 1'b1;
          end
        end
        S_HALT: begin
          // READ must fall on a get (parity 0) cycle, so burn one cycle when HALT is even.
          if (!r_parity) begin
            r_state <= S_ALIGN;
          end else begin
            r_state      <= S_READ;
            o_dma_active <= 1'b1;
            o_rw         <= 1'b1;
            o_address    <= {r_page, r_index[7:0]};
          end
        end
        S_ALIGN: begin
          r_state      <= S_READ;
          o_dma_active <= 1'b1;
          o_rw         <= 1'b1;
          o_address    <= {r_page, r_index[7:0]};
        end
        S_READ: begin
          r_latch   <= i_data;
          r_state   <= S_WRITE;
          o_rw      <= 1'b0;
          o_address <= OAMDATA_ADDRESS;
        end
        S_WRITE: begin
          r_index <= r_index + 9'd1;
          if (r_index == LAST_INDEX) begin
            r_state      <= S_IDLE;
            o_done       <= 1'b1;
            o_cpu_rdy    <= 1'b1;
            o_busy       <= 1'b0;
            o_dma_active <= 1'b0;
            o_rw         <= 1'b1;
            o_address    <= 16'h0000;
          end else begin
            r_state   <= S_READ;
            o_rw      <= 1'b1;
            o_address <= {r_page, r_index[7:0] + 8'd1};
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sprite_dma.sv
// Directed-plus-random bench for sprite_dma; expectations come from a page/index/parity model.
module tb_sprite_dma;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] cpu_addr;
  logic [7:0]  cpu_data;
  logic        cpu_rw;
  logic [7:0]  mem_data;
  logic        dut_rdy, dut_active, dut_rw, dut_busy, dut_done;
  logic [15:0] dut_address;
  logic [7:0]  dut_data;

  int passed = 0;
  int total  = 0;
  int cyc;
  int mode;
  logic [7:0] rnd_mem [256];

  sprite_dma dut (
    .i_clk(clk), .i_reset(rst), .i_cpu_address(cpu_addr), .i_cpu_data(cpu_data),
    .i_cpu_rw(cpu_rw), .i_data(mem_data), .o_cpu_rdy(dut_rdy), .o_dma_active(dut_active),
    .o_address(dut_address), .o_rw(dut_rw), .o_data(dut_data), .o_busy(dut_busy),
    .o_done(dut_done)
  );

  always #5 clk = ~clk;

  // Cycle number since reset release; the DMA get/put parity is cyc & 1.
  always @(posedge clk or posedge rst) begin
    if (rst) cyc <= 0;
    else     cyc <= cyc + 1;
  end

  function automatic logic [7:0] mem_model(input logic [15:0] a);
    logic [7:0] v;
    case (mode)
      0:       v = a[7:0];
      1:       v = ~a[7:0];
      default: v = rnd_mem[a[7:0]] ^ a[15:8];
    endcase
    return v;
  endfunction

  always_comb begin
    mem_data = 8'h00;
    case (mode)
      0:       mem_data = dut_address[7:0];
      1:       mem_data = ~dut_address[7:0];
      default: mem_data = rnd_mem[dut_address[7:0]] ^ dut_address[15:8];
    endcase
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) passed++;
    else $error("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // Trigger a transfer of `page` and follow it cycle by cycle from HALT onward.
  task automatic xfer(input string tag, input logic [7:0] page, input int want_hp,
                      input int retrig_at, input int abort_at);
    int hp, reads, writes, stall, dones, addr_err, data_err, rule_err, first_par;
    bit aborted;
    if (want_hp >= 0)
      while (((cyc + 1) & 1) != want_hp) @(negedge clk);
    hp = (cyc + 1) & 1;
    cpu_addr = 16'h4014; cpu_rw = 1'b0; cpu_data = page;
    @(negedge clk);
    cpu_addr = 16'h0000; cpu_rw = 1'b1; cpu_data = 8'h00;
    reads = 0; writes = 0; stall = 0; dones = 0;
    addr_err = 0; data_err = 0; rule_err = 0; first_par = -1; aborted = 0;
    for (int n = 0; n < 700; n++) begin
      if (!dut_rdy) stall++;
      if (dut_busy === dut_rdy) rule_err++;
      if ((dut_rw || !dut_active) && dut_data !== 8'h00) rule_err++;
      if (dut_done) begin
        dones++;
        break;
      end
      if (dut_active && dut_rw) begin
        if (first_par < 0) first_par = cyc & 1;
        if (dut_address !== {page, 8'(reads)}) addr_err++;
        reads++;
      end else if (dut_active && !dut_rw) begin
        if (dut_address !== 16'h2004 || dut_data !== mem_model({page, 8'(writes)})) data_err++;
        writes++;
        if (abort_at >= 0 && writes == abort_at) begin
          rst = 1'b1;
          #1;
          check({tag, " abort rdy"},    dut_rdy,    1);
          check({tag, " abort active"}, dut_active, 0);
          check({tag, " abort busy"},   dut_busy,   0);
          check({tag, " abort done"},   dut_done,   0);
          aborted = 1;
          break;
        end
      end
      if (n == retrig_at) begin
        cpu_addr = 16'h4014; cpu_rw = 1'b0; cpu_data = 8'h03;
      end
      @(negedge clk);
      cpu_addr = 16'h0000; cpu_rw = 1'b1; cpu_data = 8'h00;
    end
    check({tag, " addr errors"}, addr_err, 0);
    check({tag, " data errors"}, data_err, 0);
    check({tag, " rule errors"}, rule_err, 0);
    if (aborted) begin
      @(negedge clk);
      check({tag, " no done after reset"}, dut_done, 0);
      check({tag, " writes before reset"}, writes, abort_at);
      rst = 1'b0;
    end else begin
      check({tag, " done pulses"}, dones, 1);
      check({tag, " reads"},  reads,  256);
      check({tag, " writes"}, writes, 256);
      check({tag, " stall cycles"}, stall, (hp == 1) ? 513 : 514);
      check({tag, " first read parity"}, first_par, 0);
      @(negedge clk);
      check({tag, " done one cycle"}, dut_done, 0);
    end
  endtask

  initial begin
    int bad;
    for (int i = 0; i < 256; i++) rnd_mem[i] = 8'($urandom);
    rst = 1'b1; cpu_addr = 16'h0000; cpu_data = 8'h00; cpu_rw = 1'b1; mode = 0;
    repeat (2) @(negedge clk);
    check("reset rdy",     dut_rdy,     1);
    check("reset active",  dut_active,  0);
    check("reset address", dut_address, 0);
    check("reset rw",      dut_rw,      1);
    check("reset data",    dut_data,    0);
    check("reset busy",    dut_busy,    0);
    check("reset done",    dut_done,    0);
    rst = 1'b0;
    repeat ($urandom_range(1, 4)) @(negedge clk);

    mode = 0;
    xfer("odd halt", 8'h02, 1, -1, -1);
    repeat ($urandom_range(0, 3)) @(negedge clk);
    xfer("even halt", 8'h02, 0, -1, -1);

    mode = 2;
    xfer("retrigger", 8'h07, -1, 100, -1);
    xfer("reset mid", 8'(8'h10 + $urandom_range(0, 15)), -1, -1, 40);
    repeat ($urandom_range(1, 3)) @(negedge clk);
    xfer("after reset", 8'h05, -1, -1, -1);

    mode = 1;
    xfer("page ff", 8'hFF, -1, -1, -1);

    bad = 0;
    cpu_addr = 16'h4014; cpu_rw = 1'b1; cpu_data = 8'h5A;
    @(negedge clk);
    if (dut_busy || !dut_rdy || dut_active) bad++;
    cpu_addr = 16'h4015; cpu_rw = 1'b0; cpu_data = 8'h06;
    @(negedge clk);
    if (dut_busy || !dut_rdy || dut_active) bad++;
    cpu_addr = 16'h0000; cpu_rw = 1'b1; cpu_data = 8'h00;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (dut_busy || !dut_rdy || dut_active) bad++;
    end
    check("no trigger on read/4015", bad, 0);

    mode = 2;
    for (int t = 0; t < 3; t++) begin
      for (int i = 0; i < 256; i++) rnd_mem[i] = 8'($urandom);
      repeat ($urandom_range(0, 5)) @(negedge clk);
      xfer("random", 8'($urandom), -1, -1, -1);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
